// File: rtl/float_encode_pipe.sv
// Three-stage packer from an unpacked (sign, signed exponent, raw significand) value to IEEE-style Float data.
// Define FLOAT_ENCODE_SATURATE_EN to clamp rounding-path overflow to max finite instead of infinity.
module float_encode_pipe #(
  parameter int EXP    = 8,
  parameter int FRAC   = 23,
  parameter int ACC    = 32,
  parameter int EXP_IN = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sign,
  input  logic [EXP_IN-1:0]   in_exp,
  input  logic [ACC-1:0]      in_frac,
  input  logic                in_isInf,
  input  logic                in_isNan,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [EXP+FRAC:0]   out_data,
  output logic                out_inexact,
  output logic                out_overflow,
  output logic                out_underflow
);

  localparam int LZW = $clog2(ACC + 1);
  localparam int EW  = EXP_IN + 2;
  localparam int SHW = $clog2(ACC + 2);
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP) - 1);
  localparam logic signed [EW-1:0] SAT  = EW'(ACC + 1);

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance || reset;

  // S1: leading-zero count; the lowest-to-highest scan leaves the highest set bit's count.
  logic [LZW-1:0] lz;
  always_comb begin
    lz = LZW'(ACC);
    for (int i = 0; i < ACC; i++)
      if (in_frac[i]) lz = LZW'(ACC - 1 - i);
  end

  logic                 v1, sign1, inf1, nan1, zero1;
  logic [ACC-1:0]       frac1;
  logic [LZW-1:0]       lz1;
  logic signed [EW-1:0] e1;

  // S2: normalize, bias, and shift tiny values into the denormal range.
  logic signed [EW-1:0] b, sh_raw, b_clip;
  logic [SHW-1:0]       sh;
  logic [ACC-1:0]       norm, den;
  logic [2*ACC:0]       wide;
  logic                 b_pos;

  always_comb begin
    b      = e1 + BIAS;
    b_pos  = !b[EW-1] && (b != '0);
    norm   = frac1 << lz1;
    sh_raw = EW'(1) - b;
    if (b_pos)              sh = '0;
    else if (sh_raw > SAT)  sh = SHW'(ACC + 1);
    else                    sh = sh_raw[SHW-1:0];
    wide   = {norm, {(ACC + 1){1'b0}}} >> sh;
    den    = wide[2*ACC -: ACC];
    b_clip = b_pos ? b : '0;
  end

  logic                 v2, sign2, inf2, nan2, zero2, guard2, sticky2;
  logic signed [EW-1:0] b2;
  logic [FRAC:0]        mant2;

  // S3: round to nearest even; a denormal's carry lands in the hidden bit, a normal's above it.
  logic                 round_up, tiny, carry, inexact, ovf;
  logic [FRAC+1:0]      sum;
  logic signed [EW-1:0] exp_r;
  logic [EXP+FRAC:0]    data_n;
  logic                 inx_n, ovf_n, unf_n;

  always_comb begin
    round_up = guard2 && (sticky2 || mant2[0]);
    sum      = {1'b0, mant2} + {{(FRAC + 1){1'b0}}, round_up};
    tiny     = (b2 == '0);
    carry    = tiny ? sum[FRAC] : sum[FRAC+1];
    exp_r    = b2 + $signed({{(EW - 1){1'b0}}, carry});
    inexact  = guard2 || sticky2;
    ovf      = (b2 >= EMAX) || (exp_r >= EMAX);
    data_n   = '0;
    inx_n    = 1'b0;
    ovf_n    = 1'b0;
    unf_n    = 1'b0;
    if (nan2) begin
      data_n = {1'b0, {EXP{1'b1}}, {FRAC{1'b1}}};
    end else if (inf2) begin
      data_n = {sign2, {EXP{1'b1}}, {FRAC{1'b0}}};
    end else if (zero2) begin
      data_n = {sign2, {(EXP + FRAC){1'b0}}};
    end else if (ovf) begin
`ifdef FLOAT_ENCODE_SATURATE_EN
      data_n = {sign2, {(EXP - 1){1'b1}}, 1'b0, {FRAC{1'b1}}};
`else
      data_n = {sign2, {EXP{1'b1}}, {FRAC{1'b0}}};
`endif
      inx_n  = 1'b1;
      ovf_n  = 1'b1;
    end else begin
      data_n = {sign2, exp_r[EXP-1:0], sum[FRAC-1:0]};
      inx_n  = inexact;
      unf_n  = tiny && inexact;
    end
  end

  // NOTE: every register, datapath included, is reset so bubbles never carry X into out_data.
  always_ff @(posedge clock) begin
    if (reset) begin
      {v1, sign1, inf1, nan1, zero1} <= '0;
      frac1 <= '0;
      lz1   <= '0;
      e1    <= '0;
      {v2, sign2, inf2, nan2, zero2, guard2, sticky2} <= '0;
      b2    <= '0;
      mant2 <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_inexact   <= 1'b0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
    end else if (advance) begin
      v1    <= in_valid;
      sign1 <= in_sign;
      inf1  <= in_isInf;
      nan1  <= in_isNan;
      zero1 <= (in_frac == '0);
      frac1 <= in_frac;
      lz1   <= lz;
      e1    <= $signed({{2{in_exp[EXP_IN-1]}}, in_exp})
             - $signed({{(EW - LZW){1'b0}}, lz});

      v2      <= v1;
      sign2   <= sign1;
      inf2    <= inf1;
      nan2    <= nan1;
      zero2   <= zero1;
      b2      <= b_clip;
      mant2   <= den[ACC-1 -: FRAC+1];
      guard2  <= den[ACC-2-FRAC];
      sticky2 <= (|den[ACC-3-FRAC:0]) || (|wide[ACC:0]);

      out_valid     <= v2;
      out_data      <= data_n;
      out_inexact   <= inx_n;
      out_overflow  <= ovf_n;
      out_underflow <= unf_n;
    end
  end

endmodule
